// File: rtl/sample_source_arbiter.sv
// sample_source_arbiter: shares the sample FIFO write port between the MCU sample path (src0) and the test tone (src1)
//   clk_12mhz, rst_n           : clock, asynchronous active-low reset
//   enable, mode, clr_stats    : block enable, grant policy (00 src0, 01 src1, 10 round-robin, 11 src0 priority), drop-counter clear
//   srcN_valid, srcN_data      : one-cycle sample strobes with data
//   fifo_full                  : FIFO backpressure
//   fifo_write_en/data         : combinational FIFO write port
//   grant_src, active_mode     : source of the current write, latched mode
//   drop0_cnt, drop1_cnt       : saturating per-source drop counters
module sample_source_arbiter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_12mhz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              clr_stats,
  input  logic              src0_valid,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              fifo_full,
  output logic              fifo_write_en,
  output logic [DATA_W-1:0] fifo_write_data,
  output logic              grant_src,
  output logic [1:0]        active_mode,
  output logic [CNT_W-1:0]  drop0_cnt,
  output logic [CNT_W-1:0]  drop1_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] d0, d1;
  logic pend0, pend1, last_grant;
  logic en0, en1, nen0, nen1, run, g0, g1, gsel, gnt0, gnt1;
  logic load0, load1, drop0, drop1;
  always_comb begin
    state_nx = (state == IDLE) ? (enable ? RUN : IDLE) :
               (state == RUN)  ? (!enable ? IDLE : (mode != active_mode) ? SWITCH : RUN) :
               (enable ? RUN : IDLE);
  end
  always_ff @(posedge clk_12mhz or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  assign en0  = active_mode != 2'b01;
  assign en1  = active_mode != 2'b00;
  assign nen0 = mode != 2'b01;
  assign nen1 = mode != 2'b00;
  assign run  = state == RUN;
  assign g0   = run && !fifo_full && pend0 && en0;
  assign g1   = run && !fifo_full && pend1 && en1;
  // contention only arises in modes 10/11; round-robin hands the grant to the source that did not write last
  assign gsel = (g0 && g1) ? (active_mode == 2'b10 && !last_grant) : g1;
  assign fifo_write_en   = g0 || g1;
  assign gnt0            = fifo_write_en && !gsel;
  assign gnt1            = fifo_write_en && gsel;
  assign grant_src       = gnt1;
  assign fifo_write_data = gnt1 ? d1 : d0;
  // a strobe is taken when the slot is free or is being emptied this cycle; otherwise it is dropped
  assign load0 = run && en0 && src0_valid && (!pend0 || gnt0);
  assign load1 = run && en1 && src1_valid && (!pend1 || gnt1);
  assign drop0 = run && en0 && src0_valid && pend0 && !gnt0;
  assign drop1 = run && en1 && src1_valid && pend1 && !gnt1;
  always_ff @(posedge clk_12mhz or negedge rst_n)
    if (!rst_n) begin
      d0          <= '0;
      d1          <= '0;
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      last_grant  <= 1'b1;
      active_mode <= 2'b00;
      drop0_cnt   <= '0;
      drop1_cnt   <= '0;
    end else begin
      if (load0) d0 <= src0_data;
      if (load1) d1 <= src1_data;
      pend0 <= (state == IDLE) ? 1'b0 : (state == SWITCH) ? (pend0 && nen0) : (load0 || (pend0 && !gnt0));
      pend1 <= (state == IDLE) ? 1'b0 : (state == SWITCH) ? (pend1 && nen1) : (load1 || (pend1 && !gnt1));
      if (fifo_write_en) last_grant <= gsel;
      if ((state == IDLE && enable) || state == SWITCH) active_mode <= mode;
      drop0_cnt <= clr_stats ? '0 : (drop0 && drop0_cnt != '1) ? drop0_cnt + 1'b1 : drop0_cnt;
      drop1_cnt <= clr_stats ? '0 : (drop1 && drop1_cnt != '1) ? drop1_cnt + 1'b1 : drop1_cnt;
    end
endmodule

// File: tb/tb_sample_source_arbiter.sv
// tb_sample_source_arbiter: scoreboard bench for sample_source_arbiter (CNT_W = 4 build)
module tb_sample_source_arbiter;
  logic clk_12mhz = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic clr_stats = 1'b0;
  logic src0_valid = 1'b0;
  logic [15:0] src0_data = '0;
  logic src1_valid = 1'b0;
  logic [15:0] src1_data = '0;
  logic fifo_full = 1'b0;
  logic fifo_write_en;
  logic [15:0] fifo_write_data;
  logic grant_src;
  logic [1:0] active_mode;
  logic [3:0] drop0_cnt, drop1_cnt;
  typedef struct packed {logic src; logic [15:0] data;} exp_t;
  exp_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  sample_source_arbiter #(.DATA_W(16), .CNT_W(4)) dut (
    .clk_12mhz(clk_12mhz), .rst_n(rst_n), .enable(enable), .mode(mode), .clr_stats(clr_stats),
    .src0_valid(src0_valid), .src0_data(src0_data), .src1_valid(src1_valid), .src1_data(src1_data),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .grant_src(grant_src), .active_mode(active_mode), .drop0_cnt(drop0_cnt), .drop1_cnt(drop1_cnt)
  );
  always #5 clk_12mhz = ~clk_12mhz;
  always @(negedge clk_12mhz)
    if (fifo_write_en) begin
      if (fifo_full) begin
        n_assert++;
        n_fail++;
        $display("FAIL write_while_full: write_en=1 with fifo_full=1 at %0t", $time);
      end
      if (q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: src=%0d data=%h, none expected at %0t", grant_src, fifo_write_data, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_assert++;
        if (grant_src !== e.src || fifo_write_data !== e.data) begin
          n_fail++;
          $display("FAIL write: got src=%0d data=%h, expected src=%0d data=%h at %0t",
                   grant_src, fifo_write_data, e.src, e.data, $time);
        end
      end
    end
  task automatic step();
    @(posedge clk_12mhz);
    #1;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    clr_stats  = 1'b0;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic s0(input logic [15:0] d);
    src0_valid = 1'b1;
    src0_data  = d;
  endtask
  task automatic s1(input logic [15:0] d);
    src1_valid = 1'b1;
    src1_data  = d;
  endtask
  task automatic push(input logic s, input logic [15:0] d);
    q.push_back({s, d});
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(fifo_write_en), 0);
    check({tag, "_data"}, 32'(fifo_write_data), 0);
    check({tag, "_grant"}, 32'(grant_src), 0);
    check({tag, "_mode"}, 32'(active_mode), 0);
    check({tag, "_drop0"}, 32'(drop0_cnt), 0);
    check({tag, "_drop1"}, 32'(drop1_cnt), 0);
  endtask
  initial begin
    s0(16'hFFFF);
    #2;
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    enable = 1'b1;
    mode = 2'b00;
    step();
    s0(16'h1234);
    s1(16'h5555);
    push(0, 16'h1234);
    step();
    step();
    check("mode00_drop1", 32'(drop1_cnt), 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mode = 2'b10;
    step();
    check("rr_active_mode", 32'(active_mode), 2);
    s0(16'h0AAA);
    s1(16'h0555);
    push(0, 16'h0AAA);
    push(1, 16'h0555);
    step();
    step();
    step();
    s0(16'h0AAA);
    s1(16'h0555);
    push(0, 16'h0AAA);
    push(1, 16'h0555);
    step();
    step();
    step();
    fifo_full = 1'b1;
    s0(16'h0001);
    step();
    s0(16'h0002);
    step();
    s0(16'h0003);
    step();
    step();
    step();
    fifo_full = 1'b0;
    push(0, 16'h0001);
    step();
    check("bp_drop0", 32'(drop0_cnt), 2);
    step();
    mode = 2'b01;
    step();
    step();
    check("m01_active_mode", 32'(active_mode), 1);
    s1(16'h0111);
    push(1, 16'h0111);
    step();
    s1(16'h0222);
    push(1, 16'h0222);
    step();
    step();
    check("grant_strobe_drop1", 32'(drop1_cnt), 0);
    mode = 2'b11;
    step();
    step();
    fifo_full = 1'b1;
    s0(16'h0A0A);
    s1(16'h0B0B);
    step();
    mode = 2'b01;
    step();
    fifo_full = 1'b0;
    push(1, 16'h0B0B);
    step();
    step();
    step();
    check("switch_active_mode", 32'(active_mode), 1);
    mode = 2'b11;
    step();
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s0(16'h0C00 + 16'(i));
      if (i < 4) s1(16'h0E00 + 16'(i));
      step();
    end
    check("sat_drop0", 32'(drop0_cnt), 15);
    check("sat_drop1", 32'(drop1_cnt), 3);
    s0(16'h0C99);
    clr_stats = 1'b1;
    step();
    check("clr_drop0", 32'(drop0_cnt), 0);
    check("clr_drop1", 32'(drop1_cnt), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    fifo_full = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    s0(16'h0D0D);
    push(0, 16'h0D0D);
    step();
    step();
    step();
    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_source_arbiter.md
# sample_source_arbiter

Shares the single audio sample FIFO write port between two sample producers: the SPI-sniffed MCU sample path (source 0) and the locally generated test sine tone (source 1). Each source issues one-cycle sample strobes. The block buffers one sample per source and applies a mode-selected grant policy (source 0 only, source 1 only, round-robin, fixed priority). It honours `fifo_full`, counts dropped samples per source, and sequences mode changes through a one-cycle switch state so no stale sample leaks across a mode change. It sits between the sample producers and the FIFO write side, in the `clk_12mhz` domain.

## Interface
- `DATA_W`, default 16: sample width (signed, passed through unmodified).
- `CNT_W`, default 16: drop-counter width.

- `clk_12mhz`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  block enable. Low forces IDLE.
- `mode`  in  2  00 = src0 only, 01 = src1 only, 10 = round-robin, 11 = fixed priority with src0 high.
- `clr_stats`  in  1  one-cycle pulse; clears both drop counters.
- `src0_valid`  in  1  one-cycle strobe; `src0_data` is valid in the same cycle.
- `src0_data`  in  DATA_W  MCU sample.
- `src1_valid`  in  1  one-cycle strobe.
- `src1_data`  in  DATA_W  tone sample.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_write_en`  out  1  combinational FIFO write strobe.
- `fifo_write_data`  out  DATA_W  combinational, the data of the granted holding register.
- `grant_src`  out  1  source of the current write (0/1); valid only when `fifo_write_en` is high.
- `active_mode`  out  2  latched mode.
- `drop0_cnt`  out  CNT_W  source 0 drop count, saturating.
- `drop1_cnt`  out  CNT_W  source 1 drop count, saturating.

## Operation
- **Holding registers.** Each source has one data register plus a `pend` flag.
- **Source enable.** A source is enabled when its bit is allowed by `active_mode`: src0 for 00, 10, 11; src1 for 01, 10, 11.
- **Accepting a strobe.** A valid strobe from an enabled source in RUN loads the register and sets `pend`.
- **Dropping a strobe.** If `pend` is set and that source is not granted in the same cycle, the new sample is discarded. The register keeps the old sample, and `dropN_cnt` increments.
- **Valid while granted.** A valid strobe arriving in the cycle the source is granted is accepted. The old sample is written, the new one is loaded, and `pend` stays set.
- **Ignored strobes.** Strobes from a disabled source, or strobes in IDLE or SWITCH, are ignored and not counted.
- **Grant.** Evaluated combinationally each RUN cycle, only when `fifo_full` = 0. The granted source is chosen among enabled sources with `pend` set.
  - Modes 00 and 01: the single enabled source.
  - Mode 11: src0 wins when both are pending.
  - Mode 10: when both are pending, the grant goes to `!last_grant`. `last_grant` updates on every write.
- **Write outputs.** `fifo_write_en` = grant exists. On a write, the granted `pend` clears (unless reloaded that cycle). `fifo_write_data` comes from the granted register; it holds src0's register when nothing is granted.
- **FSM states:** IDLE, RUN, SWITCH.
  - IDLE: no writes, both `pend` cleared. Goes to RUN the cycle after `enable` = 1, latching `mode` into `active_mode`.
  - RUN: if `enable` = 0, go to IDLE. Otherwise, if `mode` != `active_mode`, go to SWITCH; no write occurs in that transition cycle's successor.
  - SWITCH, one cycle: no write, no strobe acceptance. `active_mode` <= `mode`. Clears `pend` for sources disabled under the new mode; a source enabled in both modes keeps its sample. Then goes to RUN, or to IDLE if `enable` = 0.
- **Precedence.** `enable` low takes priority over a mode change.
- **Counters.** Saturate at all-ones. If `clr_stats` and a drop occur in the same cycle, the result is 0.

## Timing
- **Reset values.** `pend` = 0, state = IDLE, `active_mode` = 00, `last_grant` = 1 (so src0 goes first in round-robin), counters = 0.
- **Outputs under reset.** `fifo_write_en` = 0, `fifo_write_data` = 0, `grant_src` = 0.
- **Latency.** A strobe in cycle N produces `fifo_write_en` in cycle N+1 at the earliest, when not full and not contended.
- **Throughput.** One write per cycle. Backpressure holds up to one sample per source; further strobes are dropped.
- **Reset mid-operation.** Pending samples are lost; no write is generated.
- **FIFO full.** `fifo_full` is sampled combinationally. `fifo_write_en` is never high in a cycle where `fifo_full` = 1.

## Test plan
- **Basic pass-through.** Reset, `enable` = 1, `mode` = 00, src0 strobes 0x1234 -> next cycle `fifo_write_en` = 1, data 0x1234, `grant_src` = 0. A src1 strobe is ignored and `drop1_cnt` = 0.
- **Round-robin.** Mode 10, both sources strobe (0x0AAA, 0x0555) in the same cycle -> writes 0x0AAA then 0x0555 on consecutive cycles. Repeat both strobes -> order src0 then src1 again (`last_grant` alternation).
- **Backpressure.** `fifo_full` = 1 for 5 cycles while src0 strobes 3 times (0x0001, 0x0002, 0x0003) -> `drop0_cnt` = 2. After full deasserts, exactly one write of 0x0001.
- **Strobe during grant.** A src1 strobe in the same cycle src1 is granted (mode 01) -> old value written, new value written next cycle, `drop1_cnt` unchanged.
- **Mode switch.** Both pending in mode 11, change `mode` to 01 -> one SWITCH cycle with no write, src0 sample discarded, src1 sample then written. `active_mode` = 01.
- **Stats and reset.** Saturate `drop0_cnt` (CNT_W = 4 build -> stays 15), then `clr_stats` with a simultaneous drop -> 0. Assert `rst_n` low mid-pend -> all outputs 0, no write after release until a new strobe.
